multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Finite-state sequencer that runs the shared single-cycle datapath in
// multicycle fashion. One instruction takes 3 to 5 clocks, so the ALU and a
// single instruction/data memory port can be reused across the instruction.
// Every datapath enable and mux select comes from the current state, the
// instruction-register opcode/funct, the ALU zero flag and the memory ready
// handshake. A retired-instruction counter is kept alongside.
//
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   opcode, funct        instr[31:26] and instr[5:0] from the instruction reg
//   zero                 ALU zero flag (qualifies the beq PC write)
//   memReady             memory finished the current read/write this cycle
//   memRead, memWrite    memory requests, held until memReady
//   iorD                 memory address select (0 = PC, 1 = ALUOut)
//   irWrite, pcWrite     instruction register / PC load enables
//   pcSource             PC source (00 ALUResult, 01 ALUOut, 10 jump target)
//   aluSrcA, aluSrcB     ALU operand selects
//   aluControl           ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   regDst, memToReg     register write address / data selects
//   regWrite             register file write enable
//   instrDone            one-cycle pulse on the final cycle of an instruction
//   illegalOp            one-cycle pulse in DECODE for an unsupported encoding
//   state                current state, for debug
//   instrCount           retired-instruction count, wraps to zero
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             memReady,
    output logic             memRead,
    output logic             memWrite,
    output logic             iorD,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSource,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       aluControl,
    output logic             regDst,
    output logic             memToReg,
    output logic             regWrite,
    output logic             instrDone,
    output logic             illegalOp,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instrCount
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True for the R-type funct codes the datapath supports.
    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU operation for a supported R-type funct code; add otherwise.
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] op;
        case (f)
            6'b100000: op = ALU_ADD;
            6'b100010: op = ALU_SUB;
            6'b100100: op = ALU_AND;
            6'b100101: op = ALU_OR;
            6'b101010: op = ALU_SLT;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  count_r;

    logic              mem_read_s;
    logic              mem_write_s;
    logic              ior_d_s;
    logic              ir_write_s;
    logic              pc_write_s;
    logic [1:0]        pc_source_s;
    logic              alu_src_a_s;
    logic [1:0]        alu_src_b_s;
    logic [2:0]        alu_control_s;
    logic              reg_dst_s;
    logic              mem_to_reg_s;
    logic              reg_write_s;
    logic              instr_done_s;
    logic              illegal_op_s;

    // Next-state and datapath control decode from the current state.
    always_comb begin
        state_next_s  = state_r;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        ior_d_s       = 1'b0;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        pc_source_s   = 2'b00;
        alu_src_a_s   = 1'b0;
        alu_src_b_s   = 2'b00;
        alu_control_s = ALU_ADD;
        reg_dst_s     = 1'b0;
        mem_to_reg_s  = 1'b0;
        reg_write_s   = 1'b0;
        instr_done_s  = 1'b0;
        illegal_op_s  = 1'b0;

        case (state_r)
            S_FETCH: begin
                // PC + 4 is computed while the instruction is read; the IR and
                // PC load only on the cycle memory actually delivers.
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = memReady;
                pc_write_s  = memReady;
                if (memReady) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target PC + (imm << 2) is latched into ALUOut here.
                alu_src_b_s = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) begin
                            state_next_s = S_EXECUTE;
                        end else begin
                            state_next_s = S_FETCH;
                            illegal_op_s = 1'b1;
                        end
                    end
                    OP_BEQ:  state_next_s = S_BRANCH;
                    OP_ADDI: state_next_s = S_ADDIEX;
                    OP_J:    state_next_s = S_JUMP;
                    default: begin
                        state_next_s = S_FETCH;
                        illegal_op_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                if (opcode == OP_LW) begin
                    state_next_s = S_MEMREAD;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                mem_read_s = 1'b1;
                ior_d_s    = 1'b1;
                if (memReady) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWRITE: begin
                // The store retires on the cycle memory accepts it.
                mem_write_s  = 1'b1;
                ior_d_s      = 1'b1;
                instr_done_s = memReady;
                if (memReady) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_EXECUTE: begin
                alu_src_a_s   = 1'b1;
                alu_control_s = funct_alu(funct);
                state_next_s  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                // rs - rt sets zero; the target already sits in ALUOut.
                alu_src_a_s   = 1'b1;
                alu_control_s = ALU_SUB;
                pc_source_s   = 2'b01;
                pc_write_s    = zero;
                instr_done_s  = 1'b1;
                state_next_s  = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                state_next_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JUMP: begin
                pc_source_s  = 2'b10;
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            default: begin
                // Encodings 12..15 cannot be reached; recover to FETCH.
                state_next_s = S_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (instr_done_s) begin
            count_r <= count_r + CNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    // Side-effecting strobes are gated by reset_n so they drop the instant
    // reset asserts, even though the state register reads FETCH (which
    // would otherwise request a memory read).
    assign memRead    = mem_read_s   & reset_n;
    assign memWrite   = mem_write_s  & reset_n;
    assign irWrite    = ir_write_s   & reset_n;
    assign pcWrite    = pc_write_s   & reset_n;
    assign regWrite   = reg_write_s  & reset_n;
    assign instrDone  = instr_done_s & reset_n;
    assign illegalOp  = illegal_op_s & reset_n;

    assign iorD       = ior_d_s;
    assign pcSource   = pc_source_s;
    assign aluSrcA    = alu_src_a_s;
    assign aluSrcB    = alu_src_b_s;
    assign aluControl = alu_control_s;
    assign regDst     = reg_dst_s;
    assign memToReg   = mem_to_reg_s;
    assign state      = state_r;
    assign instrCount = count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Two instances share all inputs:
// dut with the default 32-bit counter and dut4 with a 4-bit counter for the
// wrap scenario. Inputs change 1 time unit after the rising edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  opcode = 6'b000000;
    logic [5:0]  funct = 6'b000000;
    logic        zero = 1'b0;
    logic        memReady = 1'b0;

    logic        memRead, memWrite, iorD, irWrite, pcWrite;
    logic [1:0]  pcSource, aluSrcB;
    logic        aluSrcA, regDst, memToReg, regWrite, instrDone, illegalOp;
    logic [2:0]  aluControl;
    logic [3:0]  state;
    logic [31:0] instrCount;

    logic        q_memRead, q_memWrite, q_iorD, q_irWrite, q_pcWrite;
    logic [1:0]  q_pcSource, q_aluSrcB;
    logic        q_aluSrcA, q_regDst, q_memToReg, q_regWrite, q_instrDone, q_illegalOp;
    logic [2:0]  q_aluControl;
    logic [3:0]  q_state;
    logic [3:0]  q_instrCount;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clock = ~clock;

    multicycle_controller #(.CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zero(zero), .memReady(memReady), .memRead(memRead), .memWrite(memWrite),
        .iorD(iorD), .irWrite(irWrite), .pcWrite(pcWrite), .pcSource(pcSource),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
        .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .instrDone(instrDone), .illegalOp(illegalOp), .state(state),
        .instrCount(instrCount)
    );

    multicycle_controller #(.CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zero(zero), .memReady(memReady), .memRead(q_memRead), .memWrite(q_memWrite),
        .iorD(q_iorD), .irWrite(q_irWrite), .pcWrite(q_pcWrite), .pcSource(q_pcSource),
        .aluSrcA(q_aluSrcA), .aluSrcB(q_aluSrcB), .aluControl(q_aluControl),
        .regDst(q_regDst), .memToReg(q_memToReg), .regWrite(q_regWrite),
        .instrDone(q_instrDone), .illegalOp(q_illegalOp), .state(q_state),
        .instrCount(q_instrCount)
    );

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Idle one cycle in FETCH and confirm state and retired count.
    task automatic trailer(input string name);
        memReady = 1'b0;
        @(negedge clock);
        checks++;
        if (state !== 4'd0 || instrCount !== 32'(exp_cnt) || illegalOp !== 1'b0) begin
            errors++;
            $display("FAIL %s_end state=%0d count=%0d illegal=%b required state=0 count=%0d illegal=0",
                     name, state, instrCount, illegalOp, exp_cnt);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        memReady = 1'b1;
        #2;
        checks++;
        if ({memRead, memWrite, pcWrite, irWrite, regWrite, instrDone, illegalOp} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b required 0000000",
                     {memRead, memWrite, pcWrite, irWrite, regWrite, instrDone, illegalOp});
        end
        checks++;
        if (state !== 4'd0 || instrCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_state state=%0d count=%0d required 0 0", state, instrCount);
        end
        memReady = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        next_cycle();
        exp_cnt = 0;
    endtask

    task automatic test_add();
        int st[4]  = '{0, 1, 6, 7};
        logic rdy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b000000;
        funct  = 6'b100000;
        for (int i = 0; i < 4; i++) begin
            memReady = rdy[i];
            @(negedge clock);
            checks++;
            if (state !== 4'(st[i])) begin
                errors++;
                $display("FAIL add_state cycle %0d got %0d required %0d", i, state, st[i]);
            end
            checks++;
            if (regWrite !== (i == 3) || regDst !== (i == 3) || instrDone !== (i == 3)) begin
                errors++;
                $display("FAIL add_wb cycle %0d regWrite=%b regDst=%b done=%b required %b",
                         i, regWrite, regDst, instrDone, (i == 3));
            end
            if (i == 0) begin
                checks++;
                if (memRead !== 1'b1 || irWrite !== 1'b1 || pcWrite !== 1'b1 || aluSrcB !== 2'b01) begin
                    errors++;
                    $display("FAIL add_fetch memRead=%b irWrite=%b pcWrite=%b aluSrcB=%b required 1 1 1 01",
                             memRead, irWrite, pcWrite, aluSrcB);
                end
            end
            if (i == 2) begin
                checks++;
                if (aluSrcA !== 1'b1 || aluSrcB !== 2'b00 || aluControl !== 3'b010) begin
                    errors++;
                    $display("FAIL add_exec srcA=%b srcB=%b ctl=%b required 1 00 010",
                             aluSrcA, aluSrcB, aluControl);
                end
            end
            next_cycle();
        end
        exp_cnt = exp_cnt + 1;
        trailer("add");
    endtask

    task automatic test_rtype_ops();
        logic [5:0] fn[4]  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ctl[4] = '{3'b110, 3'b000, 3'b001, 3'b111};
        int st[4] = '{0, 1, 6, 7};
        opcode = 6'b000000;
        for (int k = 0; k < 4; k++) begin
            funct = fn[k];
            for (int i = 0; i < 4; i++) begin
                memReady = (i == 0);
                @(negedge clock);
                checks++;
                if (state !== 4'(st[i])) begin
                    errors++;
                    $display("FAIL rtype_state funct %b cycle %0d got %0d required %0d",
                             fn[k], i, state, st[i]);
                end
                if (i == 2) begin
                    checks++;
                    if (aluControl !== ctl[k]) begin
                        errors++;
                        $display("FAIL rtype_aluctl funct %b got %b required %b",
                                 fn[k], aluControl, ctl[k]);
                    end
                end
                next_cycle();
            end
            exp_cnt = exp_cnt + 1;
        end
        trailer("rtype");
    endtask

    task automatic test_lw_stall();
        int   st[10]  = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        logic rdy[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic mrd[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int ir_pulses = 0;
        opcode = 6'b100011;
        funct  = 6'b000000;
        for (int i = 0; i < 10; i++) begin
            memReady = rdy[i];
            @(negedge clock);
            if (irWrite === 1'b1) ir_pulses++;
            checks++;
            if (state !== 4'(st[i]) || memRead !== mrd[i]) begin
                errors++;
                $display("FAIL lw_cycle %0d state=%0d memRead=%b required %0d %b",
                         i, state, memRead, st[i], mrd[i]);
            end
            if (st[i] == 3) begin
                checks++;
                if (iorD !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_iord cycle %0d got %b required 1", i, iorD);
                end
            end
            if (i == 9) begin
                checks++;
                if (regWrite !== 1'b1 || memToReg !== 1'b1 || regDst !== 1'b0 || instrDone !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_wb regWrite=%b memToReg=%b regDst=%b done=%b required 1 1 0 1",
                             regWrite, memToReg, regDst, instrDone);
                end
            end
            next_cycle();
        end
        checks++;
        if (ir_pulses != 1) begin
            errors++;
            $display("FAIL lw_irwrite pulses=%0d required 1", ir_pulses);
        end
        exp_cnt = exp_cnt + 1;
        trailer("lw");
    endtask

    task automatic test_beq();
        int st[3] = '{0, 1, 8};
        opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            for (int i = 0; i < 3; i++) begin
                memReady = (i == 0);
                @(negedge clock);
                checks++;
                if (state !== 4'(st[i])) begin
                    errors++;
                    $display("FAIL beq_state zero=%0d cycle %0d got %0d required %0d", z, i, state, st[i]);
                end
                if (i == 2) begin
                    checks++;
                    if (pcWrite !== z[0] || pcSource !== 2'b01 || aluControl !== 3'b110 || instrDone !== 1'b1) begin
                        errors++;
                        $display("FAIL beq_branch zero=%0d pcWrite=%b pcSource=%b ctl=%b done=%b required %b 01 110 1",
                                 z, pcWrite, pcSource, aluControl, instrDone, z[0]);
                    end
                end
                next_cycle();
            end
            exp_cnt = exp_cnt + 1;
        end
        zero = 1'b0;
        trailer("beq");
    endtask

    task automatic test_addi();
        int st[4] = '{0, 1, 9, 10};
        opcode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            memReady = (i == 0);
            @(negedge clock);
            checks++;
            if (state !== 4'(st[i])) begin
                errors++;
                $display("FAIL addi_state cycle %0d got %0d required %0d", i, state, st[i]);
            end
            if (i == 2) begin
                checks++;
                if (aluSrcA !== 1'b1 || aluSrcB !== 2'b10 || regWrite !== 1'b0) begin
                    errors++;
                    $display("FAIL addi_ex srcA=%b srcB=%b regWrite=%b required 1 10 0",
                             aluSrcA, aluSrcB, regWrite);
                end
            end
            if (i == 3) begin
                checks++;
                if (regWrite !== 1'b1 || regDst !== 1'b0 || memToReg !== 1'b0 || instrDone !== 1'b1) begin
                    errors++;
                    $display("FAIL addi_wb regWrite=%b regDst=%b memToReg=%b done=%b required 1 0 0 1",
                             regWrite, regDst, memToReg, instrDone);
                end
            end
            next_cycle();
        end
        exp_cnt = exp_cnt + 1;
        trailer("addi");
    endtask

    task automatic test_illegal();
        logic [5:0] op[2] = '{6'b111111, 6'b000000};
        for (int k = 0; k < 2; k++) begin
            opcode = op[k];
            funct  = 6'b000000;
            for (int i = 0; i < 2; i++) begin
                memReady = (i == 0);
                @(negedge clock);
                checks++;
                if (state !== 4'(i) || illegalOp !== (i == 1) || instrDone !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_op %b cycle %0d state=%0d illegal=%b done=%b required %0d %b 0",
                             op[k], i, state, illegalOp, instrDone, i, (i == 1));
                end
                next_cycle();
            end
            trailer("illegal");
        end
    endtask

    task automatic test_reset_mid_store();
        int st[4] = '{0, 1, 2, 5};
        opcode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            memReady = (i == 0);
            @(negedge clock);
            checks++;
            if (state !== 4'(st[i])) begin
                errors++;
                $display("FAIL sw_state cycle %0d got %0d required %0d", i, state, st[i]);
            end
            next_cycle();
        end
        @(negedge clock);
        checks++;
        if (state !== 4'd5 || memWrite !== 1'b1 || iorD !== 1'b1 || instrDone !== 1'b0) begin
            errors++;
            $display("FAIL sw_stall state=%0d memWrite=%b iorD=%b done=%b required 5 1 1 0",
                     state, memWrite, iorD, instrDone);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (memWrite !== 1'b0 || memRead !== 1'b0 || state !== 4'd0 || instrCount !== 32'd0) begin
            errors++;
            $display("FAIL sw_abort memWrite=%b memRead=%b state=%0d count=%0d required 0 0 0 0",
                     memWrite, memRead, state, instrCount);
        end
        @(negedge clock);
        reset_n = 1'b1;
        next_cycle();
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            memReady = (i == 0 || i == 3);
            @(negedge clock);
            checks++;
            if (state !== 4'(st[i]) || instrDone !== (i == 3)) begin
                errors++;
                $display("FAIL sw_after_reset cycle %0d state=%0d done=%b required %0d %b",
                         i, state, instrDone, st[i], (i == 3));
            end
            next_cycle();
        end
        exp_cnt = exp_cnt + 1;
        trailer("sw");
    endtask

    task automatic test_count_wrap();
        int st[3] = '{0, 1, 11};
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        next_cycle();
        exp_cnt = 0;
        opcode = 6'b000010;
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < 3; i++) begin
                memReady = (i == 0);
                @(negedge clock);
                checks++;
                if (state !== 4'(st[i])) begin
                    errors++;
                    $display("FAIL j_state instr %0d cycle %0d got %0d required %0d", k, i, state, st[i]);
                end
                if (i == 0) begin
                    checks++;
                    if (q_instrCount !== 4'(k % 16)) begin
                        errors++;
                        $display("FAIL wrap_count instr %0d got %0d required %0d", k, q_instrCount, k % 16);
                    end
                end
                if (i == 2) begin
                    checks++;
                    if (pcSource !== 2'b10 || pcWrite !== 1'b1 || instrDone !== 1'b1) begin
                        errors++;
                        $display("FAIL j_jump instr %0d pcSource=%b pcWrite=%b done=%b required 10 1 1",
                                 k, pcSource, pcWrite, instrDone);
                    end
                end
                next_cycle();
            end
            exp_cnt = exp_cnt + 1;
        end
        memReady = 1'b0;
        @(negedge clock);
        checks++;
        if (q_instrCount !== 4'd1 || instrCount !== 32'd17) begin
            errors++;
            $display("FAIL wrap_final count4=%0d count32=%0d required 1 17", q_instrCount, instrCount);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_rtype_ops();
        test_lw_stall();
        test_beq();
        test_addi();
        test_illegal();
        test_reset_mid_store();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
